// File: rtl/state_timer_mc.sv
// Multi-channel state-duration timer: counts cycles while start&over qualifiers are high, captures on fall.
// Latency: count/flags registered one cycle after the sampled qualifier; capture strobe one cycle after the fall.
// Backpressure: none; the block observes qualifiers every cycle and never stalls.
module state_timer_mc #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       statestart,
    input  logic [CHANNELS-1:0]       stateover,
    input  logic                      sat_mode,
    input  logic [WIDTH-1:0]          threshold,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS*WIDTH-1:0] cap_value,
    output logic [CHANNELS-1:0]       cap_valid,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       timeout,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Per-channel "will be active next cycle", used to register busy alongside the states.
    logic [CHANNELS-1:0] active_d;
    logic                busy_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] cap_q, cap_d;
        logic             cap_vld_q, cap_vld_d;
        logic             ovf_q, ovf_d;
        logic             to_q, to_d;
        logic             en;

        // Qualifiers are already in the clk_sys domain, so no synchroniser.
        assign en = statestart[g] & stateover[g];

        // Next-state logic for the channel FSM, counter, capture and flags.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            cap_d     = cap_q;
            cap_vld_d = 1'b0;
            ovf_d     = ovf_q;
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (en) begin
                        state_d = ST_RUN;
                        count_d = ONE;
                        ovf_d   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_d   = ST_IDLE;
                        cap_d     = count_q;
                        cap_vld_d = 1'b1;
                        count_d   = '0;
                    end else if (count_q == ALL_ONES) begin
                        if (sat_mode) begin
                            state_d = ST_SAT;
                        end else begin
                            count_d = '0;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                ST_SAT: begin
                    if (!en) begin
                        state_d   = ST_IDLE;
                        cap_d     = ALL_ONES;
                        cap_vld_d = 1'b1;
                        count_d   = '0;
                    end else if (!sat_mode) begin
                        // Leaving saturation behaves like the wrap that was held off.
                        state_d = ST_RUN;
                        count_d = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = ALL_ONES;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
            // Timeout is derived from the next count so it lines up with the registered count.
            to_d = (state_d != ST_IDLE) && (threshold != '0) && (count_d >= threshold);
        end

        // Channel state registers with synchronous active-low reset.
        always_ff @(posedge clk_sys) begin
            if (!rst_n) begin
                state_q   <= ST_IDLE;
                count_q   <= '0;
                cap_q     <= '0;
                cap_vld_q <= 1'b0;
                ovf_q     <= 1'b0;
                to_q      <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                cap_q     <= cap_d;
                cap_vld_q <= cap_vld_d;
                ovf_q     <= ovf_d;
                to_q      <= to_d;
            end
        end

        assign active_d[g]                = (state_d != ST_IDLE);
        assign count[g*WIDTH +: WIDTH]     = count_q;
        assign cap_value[g*WIDTH +: WIDTH] = cap_q;
        assign cap_valid[g]               = cap_vld_q;
        assign ovf[g]                     = ovf_q;
        assign timeout[g]                 = to_q;
    end

    // Busy is registered from the next states so it tracks the FSMs cycle for cycle.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |active_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: doc/state_timer_mc.md
# state_timer_mc

Multi-channel, parametrised state-duration timer for the NMR acquisition sequencer. Each channel counts `clk_sys` cycles while both its `statestart` and `stateover` qualifiers are high, and clears when either drops. On each falling qualifier it captures the final duration with a one-cycle valid strobe. It adds per-channel saturate/wrap handling, overflow and timeout flags, so the sequencer can measure and police several state windows in parallel.

## Interface
- `WIDTH`, default 5: counter width per channel (≥2).
- `CHANNELS`, default 4: number of independent channels (≥1).
- `clk_sys  in  1`: system clock; all logic on its rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `statestart  in  CHANNELS`: per-channel start qualifier.
- `stateover  in  CHANNELS`: per-channel over qualifier.
- `sat_mode  in  1`: 1 = saturate at all-ones, 0 = wrap to 0. Shared by all channels, sampled every cycle.
- `threshold  in  WIDTH`: timeout threshold, shared; 0 disables timeout.
- `count  out  CHANNELS*WIDTH`: live counts; channel i at bits [i*WIDTH +: WIDTH].
- `cap_value  out  CHANNELS*WIDTH`: last captured duration per channel, same packing.
- `cap_valid  out  CHANNELS`: one-cycle strobe, cap_value[i] updated this cycle.
- `ovf  out  CHANNELS`: sticky wrap flag; wrap mode only.
- `timeout  out  CHANNELS`: level flag, duration reached threshold.
- `busy  out  1`: OR of all channels not in IDLE.

## Operation
- Per channel: `en_i = statestart[i] & stateover[i]`, combinational, no synchroniser. Inputs are already in the `clk_sys` domain.
- Per-channel FSM with states IDLE, RUN, SAT.
- **IDLE**
  - `count_i` = 0.
  - If `en_i`: go to RUN, `count_i` <= 1, `ovf_i` <= 0.
- **RUN**
  - If `!en_i`: go to IDLE, `cap_value_i` <= `count_i`, `cap_valid_i` <= 1, `count_i` <= 0.
  - Else if `count_i` == all-ones and `sat_mode`=1: go to SAT, count holds.
  - Else if `count_i` == all-ones and `sat_mode`=0: `count_i` <= 0, `ovf_i` <= 1, stay in RUN.
  - Else: `count_i` <= `count_i` + 1.
- **SAT**
  - Count holds at all-ones.
  - If `!en_i`: capture all-ones, strobe, clear, go to IDLE.
  - If `sat_mode` drops to 0 while in SAT: next cycle wraps to 0, sets `ovf_i`, returns to RUN.
- `ovf_i` stays set after the window ends. It clears only at the next IDLE→RUN or at reset.
- `timeout_i` = (state ≠ IDLE) & (`threshold` ≠ 0) & (`count_i` ≥ `threshold`). Registered, computed from the next-state count so it aligns with `count`. It drops with the clear.
- Arithmetic is unsigned `WIDTH`-bit modulo. No carry beyond `WIDTH`.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Reset: `count`, `cap_value`, `cap_valid`, `ovf`, `timeout`, `busy` all 0; every FSM in IDLE. Reset overrides everything, including a same-cycle `en` fall (no capture, no strobe).
- Count latency:
  - `en_i` high sampled at edge k gives `count_i` = 1 after edge k.
  - After n consecutive high samples, `count_i` = n (mod 2^WIDTH, or saturated).
- Capture:
  - First low sample at edge m: after edge m, `cap_value_i` = the pre-clear count, `cap_valid_i` = 1, `count_i` = 0.
  - `cap_valid_i` returns to 0 after edge m+1 unless another capture occurs.
- A 1-cycle `en_i` pulse gives count 1, then capture of 1 on the next cycle.
- Back-to-back windows (en high, 1 cycle low, high): capture strobe and the restart count of 1 land on consecutive cycles; `cap_value` is not disturbed by the restart.
- `cap_value_i` holds between captures.
- Reset mid-run discards the in-progress count without capture.
- `busy` is registered alongside the state, i.e. high from the cycle `count` first goes nonzero through the last RUN/SAT cycle.

## Test plan
- **Basic count/capture** (WIDTH=5, ch0): en0 high for 7 cycles, then low → count0 goes 1..7; next cycle cap_value0=7, cap_valid0=1 for exactly one cycle, count0=0; `busy` falls.
- **Saturate** (`sat_mode`=1, en high for 40 cycles) → count holds 31 from cycle 31; `ovf`=0; capture 31 on en fall.
- **Wrap** (`sat_mode`=0, en high for 40 cycles) → count 31 then 0 at cycle 32, ends at 8; `ovf`=1 and still 1 after capture of 8; clears on next window start.
- **Timeout** (`threshold`=5): `timeout` rises on the cycle count=5 and stays while running. A window of 4 cycles never asserts it. With `threshold`=0 it never asserts.
- **Multi-channel simultaneity** (CHANNELS=4): staggered windows of lengths 3, 10, 1, 6 with ch0 and ch2 falling on the same edge → each channel captures its own length, both strobes coincide, and ch1/ch3 counts are unaffected.
- **Reset mid-run and coincident fall**: count=12 when `rst_n`=0 → all outputs 0 next cycle, no strobe. Also `rst_n` low on the same edge as en falls → no capture.
